// File: rtl/eth_tx_mii_if.sv
// Payload byte stream into the MII transmitter.
//   s_data  : payload byte (destination MAC onward, no preamble or FCS)
//   s_valid : s_data holds a byte
//   s_last  : s_data is the final payload byte of the frame
//   s_ready : byte is taken on a cycle with s_valid & s_ready
// master drives the stream (the source); slave receives it (the transmitter).
interface eth_tx_mii_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/eth_tx_mii.sv
// Ethernet MII transmitter: wraps a payload byte stream as preamble, SFD, data nibbles
// (low nibble first), optional zero padding up to 60 bytes and the FCS from an external
// CRC engine, followed by an inter-frame gap.
// Ports:
//   clk, reset            : nibble clock; synchronous active-high reset
//   s_axis                : payload byte stream (eth_tx_mii_if slave)
//   tx_en, tx_data, tx_er : MII transmit side
//   crc_init              : restart the external CRC engine to all-ones
//   crc_valid, crc_data   : nibble fed to the CRC engine this cycle (bit 0 first)
//   crc_in                : inverted FCS from the CRC engine, one cycle behind crc_valid
//   busy                  : high whenever not idle
//   underflow             : one-cycle pulse when the stream starves mid-frame
module eth_tx_mii #(
  parameter bit          PAD_EN      = 1'b1,
  parameter int unsigned IFG_NIBBLES = 24
) (
  input  logic        clk,
  input  logic        reset,
  eth_tx_mii_if.slave s_axis,
  output logic        tx_en,
  output logic [3:0]  tx_data,
  output logic        tx_er,
  output logic        crc_init,
  output logic        crc_valid,
  output logic [3:0]  crc_data,
  input  logic [31:0] crc_in,
  output logic        busy,
  output logic        underflow
);

  localparam int unsigned CntW     = $clog2(IFG_NIBBLES + 16);
  localparam logic [15:0] MinBytes = 16'd60;

  typedef enum logic [2:0] {
    StIdle, StPre, StSfd, StData, StPad, StFcs, StErr, StIfg
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              nib_q, nib_d;        // 0: low-nibble cycle, 1: high-nibble cycle
  logic [15:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]       fcs_q, fcs_d;

  logic [15:0]       byte_inc;
  logic [31:0]       fcs_word;
  logic [4:0]        fcs_lsb;
  logic [3:0]        fcs_nib;

  assign byte_inc = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 16'd1;

  // crc_in only becomes valid in the first FCS cycle, so that nibble is taken directly
  // while the word is captured for the remaining seven.
  assign fcs_word = (cnt_q == '0) ? crc_in : fcs_q;
  assign fcs_lsb  = 5'd28 - {cnt_q[2:0], 2'b00};
  assign fcs_nib  = fcs_word[fcs_lsb +: 4];

  assign busy = (state_q != StIdle);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    nib_d          = nib_q;
    byte_cnt_d     = byte_cnt_q;
    fcs_d          = fcs_q;
    s_axis.s_ready = 1'b0;
    tx_en          = 1'b0;
    tx_data        = 4'h0;
    tx_er          = 1'b0;
    crc_init       = 1'b0;
    crc_valid      = 1'b0;
    underflow      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (s_axis.s_valid) begin
          state_d = StPre;
          cnt_d   = '0;
        end
      end
      StPre: begin
        tx_en   = 1'b1;
        tx_data = 4'h5;
        if (cnt_q == CntW'(14)) begin
          state_d = StSfd;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSfd: begin
        tx_en      = 1'b1;
        tx_data    = 4'hD;
        crc_init   = 1'b1;
        byte_cnt_d = '0;
        nib_d      = 1'b0;
        state_d    = StData;
      end
      StData: begin
        tx_en     = 1'b1;
        crc_valid = 1'b1;
        if (!nib_q) begin
          if (s_axis.s_valid) begin
            tx_data = s_axis.s_data[3:0];
            nib_d   = 1'b1;
          end else begin
            underflow = 1'b1;
            state_d   = StErr;
          end
        end else begin
          s_axis.s_ready = 1'b1;
          tx_data        = s_axis.s_data[7:4];
          if (s_axis.s_valid) begin
            byte_cnt_d = byte_inc;
            nib_d      = 1'b0;
            if (s_axis.s_last) begin
              state_d = (PAD_EN && (byte_inc < MinBytes)) ? StPad : StFcs;
              cnt_d   = '0;
            end
          end else begin
            // Source withdrew a half-sent byte: treated as starvation too.
            underflow = 1'b1;
            state_d   = StErr;
          end
        end
      end
      StPad: begin
        tx_en     = 1'b1;
        crc_valid = 1'b1;
        nib_d     = ~nib_q;
        if (nib_q) begin
          byte_cnt_d = byte_inc;
          if (byte_inc >= MinBytes) begin
            state_d = StFcs;
            cnt_d   = '0;
          end
        end
      end
      StFcs: begin
        tx_en   = 1'b1;
        // Most significant FCS bit goes out first, on tx_data[0].
        tx_data = {fcs_nib[0], fcs_nib[1], fcs_nib[2], fcs_nib[3]};
        if (cnt_q == '0) fcs_d = crc_in;
        if (cnt_q == CntW'(7)) begin
          state_d = StIfg;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StErr: begin
        tx_en          = 1'b1;
        tx_er          = 1'b1;
        s_axis.s_ready = 1'b1;
        if (s_axis.s_valid && s_axis.s_last) begin
          state_d = StIfg;
          cnt_d   = '0;
        end
      end
      StIfg: begin
        if (cnt_q == CntW'(IFG_NIBBLES - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    crc_data = crc_valid ? tx_data : 4'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      nib_q      <= 1'b0;
      byte_cnt_q <= '0;
      fcs_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nib_q      <= nib_d;
      byte_cnt_q <= byte_cnt_d;
      fcs_q      <= fcs_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_mii.sv
// Self-checking bench for eth_tx_mii: random payloads against a frame-level model
// (preamble, nibbles, padding, FCS computed from the payload), plus underflow,
// back-to-back and mid-FCS reset scenarios. Includes a model of the external CRC engine.
module tb_eth_tx_mii;
  localparam bit          PadEn = 1'b1;
  localparam int unsigned Ifg   = 24;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_en, tx_er, crc_init, crc_valid, busy, underflow;
  logic [3:0]  tx_data, crc_data;
  logic [31:0] crc_reg, crc_in;

  eth_tx_mii_if pl ();

  eth_tx_mii #(.PAD_EN(PadEn), .IFG_NIBBLES(Ifg)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_axis    (pl),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_er     (tx_er),
    .crc_init  (crc_init),
    .crc_valid (crc_valid),
    .crc_data  (crc_data),
    .crc_in    (crc_in),
    .busy      (busy),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_nib(input logic [31:0] r, input logic [3:0] n);
    logic [31:0] c;
    logic        fb;
    c = r;
    for (int j = 0; j < 4; j++) begin
      fb = c[31] ^ n[j];
      c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
    end
    return c;
  endfunction

  // External CRC engine: register updates on crc_valid, crc_in is its inverse.
  always @(posedge clk) begin
    if (reset || crc_init) crc_reg <= 32'hFFFF_FFFF;
    else if (crc_valid)    crc_reg <= crc_nib(crc_reg, crc_data);
  end
  assign crc_in = ~crc_reg;

  // Monitor state, sampled at the falling edge.
  logic [3:0]  cap[$];
  logic [3:0]  exp_q[$];
  logic [7:0]  frm[$];
  int          gaps[$];
  int          er_cnt, uf_cnt, hs_cnt, low_run;
  logic        prev_en = 1'b0;
  logic        last_er = 1'b0;

  initial begin
    low_run = 0;
    forever begin
      @(negedge clk);
      if (tx_en) begin
        if (!prev_en) gaps.push_back(low_run);
        low_run = 0;
        cap.push_back(tx_data);
        last_er = tx_er;
      end else begin
        low_run++;
      end
      if (tx_er) er_cnt++;
      if (underflow) uf_cnt++;
      if (pl.s_valid && pl.s_ready) hs_cnt++;
      prev_en = tx_en;
    end
  end

  task automatic clear_mon();
    cap.delete();
    exp_q.delete();
    gaps.delete();
    er_cnt = 0;
    uf_cnt = 0;
    hs_cnt = 0;
  endtask

  // Appends the expected MII nibble stream of the frame in frm to exp_q.
  task automatic build_exp();
    logic [3:0]  body[$];
    logic [31:0] r, fcs;
    logic [3:0]  nb;
    int          n;
    for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    foreach (frm[i]) begin
      body.push_back(frm[i][3:0]);
      body.push_back(frm[i][7:4]);
    end
    n = frm.size();
    while (PadEn && n < 60) begin
      body.push_back(4'h0);
      body.push_back(4'h0);
      n++;
    end
    r = 32'hFFFF_FFFF;
    foreach (body[i]) r = crc_nib(r, body[i]);
    fcs = ~r;
    foreach (body[i]) exp_q.push_back(body[i]);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) nb[j] = fcs[31 - 4 * k - j];
      exp_q.push_back(nb);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte was taken.
  task automatic push_byte(input logic [7:0] d, input logic last);
    bit done = 1'b0;
    pl.s_data  = d;
    pl.s_last  = last;
    pl.s_valid = 1'b1;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      done = pl.s_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check_eq("handshake_wait", done, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      #1;
      if (!busy) break;
    end
    check_eq({tag, "_idle"}, busy, 0);
    check_eq({tag, "_ifg_plus_idle"}, low_run, Ifg + 1);
  endtask

  task automatic compare_stream(input string tag, input int upto);
    int bad = -1;
    for (int i = 0; i < upto && i < cap.size() && i < exp_q.size(); i++)
      if (bad < 0 && cap[i] !== exp_q[i]) bad = i;
    check_eq({tag, "_first_bad_nibble"}, bad, -1);
  endtask

  task automatic check_residue(input string tag);
    logic [31:0] r = 32'hFFFF_FFFF;
    for (int i = 16; i < cap.size(); i++) r = crc_nib(r, cap[i]);
    check_eq({tag, "_residue"}, r, 32'hC704DD7B);
  endtask

  task automatic run_frame(input string tag);
    clear_mon();
    build_exp();
    foreach (frm[i]) push_byte(frm[i], i == frm.size() - 1);
    pl.s_valid = 1'b0;
    pl.s_last  = 1'b0;
    wait_idle(tag);
    check_eq({tag, "_len"}, cap.size(), exp_q.size());
    compare_stream(tag, exp_q.size());
    check_residue(tag);
    check_eq({tag, "_no_tx_er"}, er_cnt, 0);
  endtask

  task automatic rand_frame(input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lens[6];
    logic [7:0] fa[$];
    // Reset held with s_valid high: must stay idle with all outputs low.
    pl.s_valid = 1'b1;
    pl.s_data  = 8'h3C;
    pl.s_last  = 1'b0;
    reset      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_tx_en", tx_en, 0);
    check_eq("rst_tx_er", tx_er, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_crc_init", crc_init, 0);
    check_eq("rst_crc_valid", crc_valid, 0);
    check_eq("rst_crc_data", crc_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_underflow", underflow, 0);
    check_eq("rst_s_ready", pl.s_ready, 0);
    @(posedge clk);
    #1;
    pl.s_valid = 1'b0;
    reset      = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // 64-byte counting frame.
    frm.delete();
    for (int i = 0; i < 64; i++) frm.push_back(8'(i));
    run_frame("f64");
    check_eq("f64_tx_en_cycles", cap.size(), 152);
    check_eq("f64_handshakes", hs_cnt, 64);

    // 1-byte frame, padded.
    frm.delete();
    frm.push_back(8'hAB);
    run_frame("f1");
    check_eq("f1_tx_en_cycles", cap.size(), 144);

    // Padding boundary and random lengths.
    lens[0] = 59;
    lens[1] = 60;
    lens[2] = 61;
    lens[3] = $urandom_range(1, 1518);
    lens[4] = $urandom_range(1, 1518);
    lens[5] = $urandom_range(1, 100);
    for (int f = 0; f < 6; f++) begin
      rand_frame(lens[f]);
      run_frame($sformatf("rnd%0d_len%0d", f, lens[f]));
    end

    // Underflow after byte 10: 3 starved cycles, then 5 bytes ending in s_last.
    rand_frame(15);
    clear_mon();
    build_exp();
    for (int i = 0; i < 10; i++) push_byte(frm[i], 1'b0);
    pl.s_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    for (int i = 10; i < 15; i++) push_byte(frm[i], i == 14);
    pl.s_valid = 1'b0;
    pl.s_last  = 1'b0;
    wait_idle("uf");
    check_eq("uf_pulses", uf_cnt, 1);
    check_eq("uf_tx_er_cycles", er_cnt, 3 - 1 + 5);
    check_eq("uf_tx_en_cycles", cap.size(), 36 + 3 + 5);
    check_eq("uf_ends_in_err", last_er, 1);
    check_eq("uf_err_data", cap[cap.size() - 1], 0);
    compare_stream("uf_prefix", 36);

    // Back-to-back frames with s_valid held high across the gap.
    clear_mon();
    rand_frame(20);
    fa = frm;
    build_exp();
    rand_frame(65);
    build_exp();
    foreach (fa[i]) push_byte(fa[i], i == fa.size() - 1);
    foreach (frm[i]) push_byte(frm[i], i == frm.size() - 1);
    pl.s_valid = 1'b0;
    pl.s_last  = 1'b0;
    wait_idle("b2b");
    check_eq("b2b_len", cap.size(), exp_q.size());
    compare_stream("b2b", exp_q.size());
    check_eq("b2b_frames", gaps.size(), 2);
    check_eq("b2b_gap", (gaps.size() > 1) ? gaps[1] : -1, Ifg + 1);

    // Reset in FCS nibble 3 of a 60-byte frame.
    rand_frame(60);
    clear_mon();
    foreach (frm[i]) push_byte(frm[i], i == frm.size() - 1);
    pl.s_valid = 1'b0;
    pl.s_last  = 1'b0;
    for (int t = 0; t < 400 && cap.size() < 140; t++) begin
      @(negedge clk);
      #1;
    end
    check_eq("fcs3_reached", cap.size(), 140);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_eq("fcs_rst_tx_en", tx_en, 0);
    check_eq("fcs_rst_busy", busy, 0);
    check_eq("fcs_rst_s_ready", pl.s_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("fcs_rst_no_more_tx", cap.size(), 140);
    rand_frame(61);
    run_frame("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
